ws2812_serializer: RTL and testbench
====================================

WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, giving the LEDs per frame (1..255).
REQ-002 The block SHALL have parameter T0H, default 20, giving the high cycles of a '0' bit.
REQ-003 The block SHALL have parameter T1H, default 40, giving the high cycles of a '1' bit.
REQ-004 The block SHALL have parameter BIT_CYC, default 63, giving the total cycles per bit (T0H < T1H < BIT_CYC).
REQ-005 The block SHALL have parameter LATCH_CYC, default 3000, giving the low cycles that latch the strip after a frame.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port frame_start, input, 1 bit: single-cycle request to send one frame.
REQ-009 The block SHALL have port cor_led, input, 24 bits: pixel colour {R[23:16], G[15:8], B[7:0]}, as produced by the upstream colour mixer.
REQ-010 The block SHALL have port cor_valid, input, 1 bit: cor_led is valid.
REQ-011 The block SHALL have port cor_ready, output, 1 bit: the block is requesting a pixel.
REQ-012 The block SHALL have port led_idx, output, 8 bits: index of the pixel requested or being sent.
REQ-013 The block SHALL have port dout, output, 1 bit: the serial line to the strip.
REQ-014 The block SHALL have port busy, output, 1 bit: high when the block is not IDLE.
REQ-015 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of the latch period.

Function
REQ-016 The block SHALL have states IDLE, FETCH, SEND and LATCH.
REQ-017 In IDLE, when frame_start=1, the block SHALL go to FETCH, with led_idx=0; otherwise it stays in IDLE.
REQ-018 cor_ready SHALL be 1 only in FETCH, and a pixel SHALL be accepted on a cycle where cor_valid=1 and cor_ready=1.
REQ-019 On acceptance, the block SHALL register the pixel reordered to GRB, as {cor_led[15:8], cor_led[23:16], cor_led[7:0]}, and go to SEND on the next cycle.
REQ-020 In FETCH with cor_valid=0, the block SHALL hold dout=0 indefinitely; stall length is the upstream's responsibility.
REQ-021 SEND SHALL shift 24 bits, MSB first.
REQ-022 Each bit in SEND SHALL occupy exactly BIT_CYC cycles.
REQ-023 During each bit, dout SHALL be 1 for the first T1H cycles if the bit is 1, or the first T0H cycles if the bit is 0, then 0 for the remainder.
REQ-024 The first high cycle of bit 23 SHALL be the cycle after acceptance.
REQ-025 After bit 0, if led_idx < NUM_LEDS-1, the block SHALL increment led_idx and go to FETCH; otherwise it SHALL go to LATCH.
REQ-026 The FETCH gap between pixels SHALL be at least 1 cycle of dout=0, which extends the preceding low time.
REQ-027 In LATCH, dout SHALL be 0 for exactly LATCH_CYC cycles; the block SHALL then pulse frame_done for 1 cycle and return to IDLE in the same transition.
REQ-028 frame_start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-029 cor_valid outside FETCH SHALL be ignored.
REQ-030 led_idx SHALL never exceed NUM_LEDS-1; pixel, bit and cycle counters SHALL be sized to their parameter maxima and SHALL NOT wrap within a frame.
REQ-031 dout, cor_ready and frame_done SHALL be registered outputs.

Reset
REQ-032 When reset_n=0 at a clock edge, the block SHALL go to IDLE with dout=0, cor_ready=0, busy=0, frame_done=0 and led_idx=0, with all counters and the shift register cleared.
REQ-033 Reset asserted mid-SEND or mid-LATCH SHALL abort the frame, drive dout=0 on the next cycle and produce no frame_done.
REQ-034 After reset_n returns to 1, the block SHALL wait for a new frame_start.

Verification
REQ-035 Scenario: NUM_LEDS=1, cor_led=24'hFF0000, cor_valid held 1, frame_start pulse -> 8 bits of 20 high/43 low, then 8 bits of 40 high/23 low, then 8 bits of 20 high/43 low; then 3000 low cycles; then frame_done.
REQ-036 Scenario: NUM_LEDS=4 with colours 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h000001 -> led_idx steps 0..3, each pixel is serialised in GRB order, and exactly 4 handshakes occur.
REQ-037 Scenario: cor_valid withheld 100 cycles in FETCH of pixel 2 -> dout=0 and cor_ready=1 for all 100 cycles, with led_idx=2; transmission resumes correctly after cor_valid.
REQ-038 Scenario: frame_start pulsed during SEND and again during LATCH -> no effect, with exactly one frame_done.
REQ-039 Scenario: reset_n=0 at cycle 30 of bit 10 of pixel 0 -> dout=0 and busy=0 on the next cycle, and no frame_done.
REQ-040 Scenario: frame_start on the same cycle as frame_done -> ignored; a frame_start one cycle later starts a new frame.

Source files
------------

// File: rtl/ws2812_serializer.sv
// WS2812 strip driver: fetches NUM_LEDS pixels over a valid/ready handshake and
// emits each as 24 GRB-ordered, pulse-width-coded bits, followed by a latch gap.
module ws2812_serializer #(
  parameter int NUM_LEDS  = 8,
  parameter int T0H       = 20,
  parameter int T1H       = 40,
  parameter int BIT_CYC   = 63,
  parameter int LATCH_CYC = 3000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [23:0] cor_led,
  input  logic        cor_valid,
  output logic        cor_ready,
  output logic [7:0]  led_idx,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H_C      = CW'(T0H);
  localparam logic [CW-1:0] T1H_C      = CW'(T1H);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);
  localparam logic [7:0]    LED_LAST   = 8'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [LW-1:0] latch_cnt_q, latch_cnt_d;
  logic [7:0]    led_idx_q, led_idx_d;
  logic          dout_q, dout_d;
  logic          cor_ready_q, cor_ready_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] high_len;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      latch_cnt_q  <= '0;
      led_idx_q    <= '0;
      dout_q       <= 1'b0;
      cor_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      latch_cnt_q  <= latch_cnt_d;
      led_idx_q    <= led_idx_d;
      dout_q       <= dout_d;
      cor_ready_q  <= cor_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    latch_cnt_d = latch_cnt_q;
    led_idx_d   = led_idx_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = FETCH;
          led_idx_d = 8'd0;
        end
      end

      FETCH: begin
        if (cor_valid && cor_ready_q) begin
          shift_d   = {cor_led[15:8], cor_led[23:16], cor_led[7:0]};
          bit_cnt_d = 5'd23;
          cyc_cnt_d = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == 5'd0) begin
            if (led_idx_q < LED_LAST) begin
              led_idx_d = led_idx_q + 8'd1;
              state_d   = FETCH;
            end else begin
              latch_cnt_d = '0;
              state_d     = LATCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
            shift_d   = {shift_q[22:0], 1'b0};
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end

      LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          latch_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + LW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they come straight out of flops
  // yet line up with the state they describe; frame_done marks the final latch cycle.
  always_comb begin
    high_len     = shift_d[23] ? T1H_C : T0H_C;
    dout_d       = (state_d == SEND) && (cyc_cnt_d < high_len);
    cor_ready_d  = (state_d == FETCH);
    frame_done_d = (state_d == LATCH) && (latch_cnt_d == LATCH_LAST);
  end

  assign dout       = dout_q;
  assign cor_ready  = cor_ready_q;
  assign frame_done = frame_done_q;
  assign led_idx    = led_idx_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: directed frames plus random pixels, checked
// cycle by cycle against the expected pulse train derived from pixel colours.
module tb_ws2812_serializer;

  localparam int NUM_LEDS  = 4;
  localparam int T0H       = 20;
  localparam int T1H       = 40;
  localparam int BIT_CYC   = 63;
  localparam int LATCH_CYC = 3000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [23:0] cor_led;
  logic        cor_valid;
  logic        cor_ready;
  logic [7:0]  led_idx;
  logic        dout;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  logic [23:0] pix [NUM_LEDS];
  int   stall_pix;
  int   stall_len;
  int   send_pulse_pix;
  int   latch_pulse_at;
  logic pulse_at_done;

  ws2812_serializer #(
    .NUM_LEDS(NUM_LEDS), .T0H(T0H), .T1H(T1H), .BIT_CYC(BIT_CYC), .LATCH_CYC(LATCH_CYC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .cor_led(cor_led), .cor_valid(cor_valid), .cor_ready(cor_ready),
    .led_idx(led_idx), .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cor_valid && cor_ready) hs_cnt++;
    if (frame_done) done_cnt++;
  end

  // Strip wire order is G, R, B with MSB first; bit b of that word sets the pulse width.
  function automatic int high_len(input logic [23:0] c, input int b);
    logic [23:0] grb;
    grb = {c[15:8], c[23:16], c[7:0]};
    return grb[b] ? T1H : T0H;
  endfunction

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_line(input string tag, input logic e_dout, input logic e_ready,
                             input logic e_busy, input int e_idx);
    chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
    chk({tag, ".cor_ready"}, 32'(cor_ready), 32'(e_ready));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    if (e_idx >= 0) chk({tag, ".led_idx"}, 32'(led_idx), 32'(e_idx));
  endtask

  task automatic start_frame;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  task automatic run_frame;
    int hs0;
    int done0;
    hs0 = hs_cnt;
    done0 = done_cnt;
    for (int p = 0; p < NUM_LEDS; p++) begin
      for (int s = 0; s < ((p == stall_pix) ? stall_len : 0); s++) begin
        cor_valid = 1'b0;
        cor_led = 24'($urandom);
        expect_line("stall", 1'b0, 1'b1, 1'b1, p);
        tick;
      end
      expect_line("fetch", 1'b0, 1'b1, 1'b1, p);
      cor_valid = 1'b1;
      cor_led = pix[p];
      tick;
      for (int b = 23; b >= 0; b--) begin
        for (int k = 0; k < BIT_CYC; k++) begin
          expect_line("send", (k < high_len(pix[p], b)), 1'b0, 1'b1, p);
          chk("send.frame_done", 32'(frame_done), 32'd0);
          cor_valid = 1'($urandom_range(0, 1));
          cor_led = 24'($urandom);
          frame_start = (p == send_pulse_pix) && (b == 12) && (k == 7);
          tick;
        end
      end
    end
    frame_start = 1'b0;
    for (int k = 0; k < LATCH_CYC; k++) begin
      expect_line("latch", 1'b0, 1'b0, 1'b1, NUM_LEDS - 1);
      chk("latch.frame_done", 32'(frame_done), 32'(k == LATCH_CYC - 1));
      cor_valid = 1'($urandom_range(0, 1));
      cor_led = 24'($urandom);
      frame_start = (k == latch_pulse_at) || (pulse_at_done && (k == LATCH_CYC - 1));
      tick;
    end
    frame_start = 1'b0;
    cor_valid = 1'b0;
    expect_line("after_frame", 1'b0, 1'b0, 1'b0, -1);
    chk("after_frame.frame_done", 32'(frame_done), 32'd0);
    chk("handshakes", 32'(hs_cnt - hs0), 32'(NUM_LEDS));
    chk("frame_done_count", 32'(done_cnt - done0), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    frame_start = 1'b0;
    cor_valid = 1'b0;
    cor_led = '0;
    stall_pix = -1;
    stall_len = 0;
    send_pulse_pix = -1;
    latch_pulse_at = -1;
    pulse_at_done = 1'b0;

    repeat (3) tick;
    expect_line("reset", 1'b0, 1'b0, 1'b0, 0);
    chk("reset.frame_done", 32'(frame_done), 32'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cor_valid = 1'($urandom_range(0, 1));
      cor_led = 24'($urandom);
      tick;
      expect_line("idle_wait", 1'b0, 1'b0, 1'b0, 0);
    end
    cor_valid = 1'b0;

    // Directed colours, 100-cycle stall on pixel 2, ignored frame_start pulses
    // in SEND, in LATCH and on the frame_done cycle.
    pix[0] = 24'h00FF00;
    pix[1] = 24'h0000FF;
    pix[2] = 24'hFFFF00;
    pix[3] = 24'h000001;
    stall_pix = 2;
    stall_len = 100;
    send_pulse_pix = 1;
    latch_pulse_at = 500;
    pulse_at_done = 1'b1;
    start_frame;
    run_frame;

    for (int p = 0; p < NUM_LEDS; p++) pix[p] = 24'($urandom);
    stall_pix = $urandom_range(0, NUM_LEDS - 1);
    stall_len = $urandom_range(1, 20);
    send_pulse_pix = -1;
    latch_pulse_at = -1;
    pulse_at_done = 1'b0;
    start_frame;
    run_frame;

    // Abort with reset at cycle 30 of bit 10 of pixel 0.
    pix[0] = 24'($urandom);
    start_frame;
    expect_line("abort.fetch", 1'b0, 1'b1, 1'b1, 0);
    cor_valid = 1'b1;
    cor_led = pix[0];
    tick;
    cor_valid = 1'b0;
    for (int n = 0; n <= 13 * BIT_CYC + 30; n++) begin
      expect_line("abort.send", ((n % BIT_CYC) < high_len(pix[0], 23 - n / BIT_CYC)),
                  1'b0, 1'b1, 0);
      if (n == 13 * BIT_CYC + 30) reset_n = 1'b0;
      tick;
    end
    expect_line("abort.reset", 1'b0, 1'b0, 1'b0, 0);
    chk("abort.frame_done", 32'(frame_done), 32'd0);
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      expect_line("abort.idle", 1'b0, 1'b0, 1'b0, 0);
      chk("abort.idle.frame_done", 32'(frame_done), 32'd0);
    end
    chk("frame_done_total", 32'(done_cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
